// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch
//                sequencer: FSM state encoding, instruction size, default
//                program bounds and a small alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch FSM states, explicitly encoded
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [31:0] DEFAULT_PC_RESET = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_WRAP  = 32'h0000_00FC;

  // A word address must have its two low bits clear
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Combinational next-PC selection. Sequential increment with
//                wrap at the program bound, redirect override with forced
//                word alignment, and misaligned-target detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(DEFAULT_PC_RESET),
  parameter logic [ADDR_W-1:0] PC_WRAP  = ADDR_W'(DEFAULT_PC_WRAP)
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              advance,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              misalign
);

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_redirect_aligned;

  // Redirect beats the sequential advance; otherwise the PC holds
  always_comb begin
    w_pc_inc           = (pc == PC_WRAP) ? PC_RESET : pc + ADDR_W'(INSTR_BYTES);
    w_redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
    misalign           = redirect_valid && is_misaligned(redirect_pc[1:0]);
    if (redirect_valid) begin
      pc_next = w_redirect_aligned;
    end else if (advance) begin
      pc_next = w_pc_inc;
    end else begin
      pc_next = pc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Fetches instruction words from a 1-cycle-latency synchronous
//                memory and presents them with a valid/ready handshake.
//                Owns the PC, honours redirects, counts accepted words and
//                flags misaligned redirect targets (sticky).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(DEFAULT_PC_RESET),
  parameter logic [ADDR_W-1:0] PC_WRAP  = ADDR_W'(DEFAULT_PC_WRAP)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              misalign_err,
  output logic [31:0]       fetch_count
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_handshake;
  logic              w_misalign;

  assign w_handshake = instr_valid & instr_ready;

  pc_gen #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (PC_RESET),
    .PC_WRAP  (PC_WRAP)
  ) u_pc_gen (
    .pc             (r_pc),
    .advance        (w_handshake),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_next        (w_pc_next),
    .misalign       (w_misalign)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a redirect restarts fetching from any state, dropping any read in flight
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = enable ? REQ : IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = enable ? REQ : IDLE;
        REQ:     w_state_next = WAIT;
        WAIT:    w_state_next = HOLD;
        HOLD:    if (w_handshake) w_state_next = enable ? REQ : IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; the address bus idles at zero
  always_comb begin
    imem_req    = (r_state == REQ);
    imem_addr   = (r_state == REQ) ? r_pc : '0;
    instr_valid = (r_state == HOLD);
  end

  // PC, captured instruction, accepted count and sticky misalign flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc         <= PC_RESET;
      instr_data   <= '0;
      instr_pc     <= '0;
      fetch_count  <= '0;
      misalign_err <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (r_state == WAIT && !redirect_valid) begin
        instr_data <= imem_rdata;
        instr_pc   <= r_pc;
      end
      if (w_handshake) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (w_misalign) begin
        misalign_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. Directed scenarios
//                followed by a randomized phase, checked against a
//                transaction-level model of the fetch stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam logic [31:0] T_RESET = 32'h0000_0000;
  localparam logic [31:0] T_WRAP  = 32'h0000_0008;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // model of the fetch stream: address of the next word to be presented
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_mis;
  logic        prev_req, prev_redir, prev_hs;

  logic [31:0] mem [0:255];

  fetch_sequencer #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .PC_RESET (T_RESET),
    .PC_WRAP  (T_WRAP)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  always #5 clock = ~clock;

  // synchronous memory: data one cycle after the strobe, junk otherwise
  always @(posedge clock) begin
    if (imem_req) imem_rdata <= mem[imem_addr[9:2]];
    else          imem_rdata <= $urandom();
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] seq_next(input logic [31:0] a);
    return (a == T_WRAP) ? T_RESET : a + 32'd4;
  endfunction

  // one clock cycle: check outputs against the model, apply this cycle's events
  task automatic tick();
    logic hs;
    if (reset) begin
      m_pc = T_RESET; m_count = 32'd0; m_mis = 1'b0;
      prev_req = 1'b0; prev_redir = 1'b0; prev_hs = 1'b0;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
    end else begin
      check("count", fetch_count, m_count);
      check("misalign", 32'(misalign_err), 32'(m_mis));
      if (prev_redir || prev_hs) check("valid_drop", 32'(instr_valid), 32'd0);
      if (prev_req && !prev_redir) check("req_single", 32'(imem_req), 32'd0);
      if (instr_valid) begin
        check("req_while_valid", 32'(imem_req), 32'd0);
        check("instr_pc", instr_pc, m_pc);
        check("instr_data", instr_data, mem[m_pc[9:2]]);
      end
      if (imem_req) check("imem_addr", imem_addr, m_pc);
      hs = instr_valid & instr_ready;
      if (hs) begin
        m_count = m_count + 32'd1;
        m_pc    = seq_next(m_pc);
      end
      if (redirect_valid) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
      end
      prev_req = imem_req; prev_redir = redirect_valid; prev_hs = hs;
    end
    @(posedge clock);
    @(negedge clock);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (instr_valid !== 1'b1 && n < budget) begin tick(); n++; end
    check(tag, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (imem_req !== 1'b1 && n < budget) begin tick(); n++; end
    check(tag, 32'(imem_req), 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] c0;
    for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    mem[0] = 32'h01c38333;
    mem[1] = 32'h41c38333;
    mem[2] = 32'h01c3c333;

    reset = 1'b1; enable = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    m_pc = T_RESET; m_count = 32'd0; m_mis = 1'b0;
    prev_req = 1'b0; prev_redir = 1'b0; prev_hs = 1'b0;
    repeat (2) @(negedge clock);

    // reset state
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", instr_data, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_count", fetch_count, 32'd0);
    reset = 1'b0;
    tick(); tick();
    check("idle_no_req", 32'(imem_req), 32'd0);

    // stream of three words, first valid on the third edge after enable
    enable = 1'b1; instr_ready = 1'b1;
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin tick(); n++; end
    check("t1_latency", 32'(n), 32'd3);
    check("t1_data0", instr_data, 32'h01c38333);
    tick();
    wait_valid("t1_wait1", 10);
    check("t1_data1", instr_data, 32'h41c38333);
    check("t1_pc1", instr_pc, 32'h4);
    tick();
    wait_valid("t1_wait2", 10);
    check("t1_data2", instr_data, 32'h01c3c333);
    check("t1_pc2", instr_pc, 32'h8);
    tick();
    check("t1_count", fetch_count, 32'd3);

    // wrap back to the reset PC after the bound
    wait_valid("t3_wait", 10);
    check("t3_wrap_pc", instr_pc, 32'h0);
    tick();

    // backpressure on the word at 4
    instr_ready = 1'b0;
    wait_valid("t2_wait", 10);
    check("t2_pc", instr_pc, 32'h4);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_hold_valid", 32'(instr_valid), 32'd1);
      check("t2_hold_pc", instr_pc, 32'h4);
      check("t2_hold_data", instr_data, 32'h41c38333);
      check("t2_hold_noreq", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    check("t2_count", fetch_count, 32'd5);
    wait_req("t2_req", 5);
    check("t2_next_addr", imem_addr, 32'h8);

    // misaligned redirect while the read of word 4 is in flight
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 32'h4) && n < 30) begin tick(); n++; end
    check("t4_find", imem_addr, 32'h4);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    wait_req("t4_req", 5);
    check("t4_addr", imem_addr, 32'h40);
    check("t4_mis", 32'(misalign_err), 32'd1);
    wait_valid("t4_wait", 10);
    check("t4_pc", instr_pc, 32'h40);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    check("t4_mis_sticky", 32'(misalign_err), 32'd1);

    // redirect coinciding with the handshake of word 0
    instr_ready = 1'b0;
    wait_valid("t5_wait", 10);
    check("t5_pc", instr_pc, 32'h0);
    c0 = fetch_count;
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    check("t5_count", fetch_count, c0 + 32'd1);
    wait_req("t5_req", 5);
    check("t5_addr", imem_addr, 32'h20);

    // asynchronous reset while a read is in flight
    tick();
    #2 reset = 1'b1;
    #1;
    check("t6_req", 32'(imem_req), 32'd0);
    check("t6_addr", imem_addr, 32'd0);
    check("t6_valid", 32'(instr_valid), 32'd0);
    check("t6_data", instr_data, 32'd0);
    check("t6_pc", instr_pc, 32'd0);
    check("t6_mis", 32'(misalign_err), 32'd0);
    check("t6_count", fetch_count, 32'd0);
    @(negedge clock);
    tick(); tick();
    reset = 1'b0;
    wait_req("t6_req_after", 5);
    check("t6_first_addr", imem_addr, T_RESET);
    wait_valid("t6_wait", 10);
    check("t6_first_pc", instr_pc, T_RESET);
    tick();

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      enable      = ($urandom_range(0, 9) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = {22'd0, 8'($urandom_range(0, 255)),
                       ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      end
      tick();
    end

    // drain: fetching must resume
    enable = 1'b1; instr_ready = 1'b1;
    wait_valid("drain_wait", 20);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
